// File: rtl/conv_row_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_row_accumulator_if
// Brief    : Partial-sum input stream and result output stream of the row
//            accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_row_accumulator_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = IN_W + 4
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_partial;
    logic [7:0]       out_index;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_partial, out_index
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_partial, out_index
    );
endinterface
`default_nettype wire

// File: rtl/conv_row_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : conv_row_accumulator
// Brief    : Sums ACC_LEN kernel-row partial sums into one result, with early
//            flush and a single-entry output slot.
// Revision : 1.0 - initial release
// ============================================================================
module conv_row_accumulator #(
    parameter int IN_W    = 18,
    parameter int ACC_LEN = 4,
    parameter int OUT_W   = IN_W + 4
) (
    input wire                      clk,
    input wire                      reset,
    input wire                      enable,
    input wire                      flush,
    conv_row_accumulator_if.slave   bus
);
    localparam int                 c_cnt_w     = $clog2(ACC_LEN);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(ACC_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_acc;
    logic [c_cnt_w-1:0] r_beat_cnt;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_partial;
    logic [7:0]         r_out_index;
    logic [7:0]         r_next_index;
    logic [1:0]         r_rst_sync;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_slot_free;
    logic               w_flush_emit;
    logic               w_load;
    logic [OUT_W-1:0]   w_sum;
    logic [OUT_W-1:0]   w_emit_data;

    // in_ready stays low until reset release has passed through two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_in_ready  = r_rst_sync[1] && enable &&
                         !(r_out_valid && !bus.out_ready &&
                           ((r_beat_cnt == c_last_beat) || flush));
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_last      = w_accept && (r_beat_cnt == c_last_beat);
    assign w_slot_free = !r_out_valid || bus.out_ready;
    // A flush alongside an accepted beat also covers a first beat from IDLE.
    assign w_flush_emit = !w_last && flush && enable && w_slot_free &&
                          ((r_state == ST_ACCUM) || w_accept);
    assign w_load      = w_last || w_flush_emit;
    // r_acc is zero in IDLE, so the same adder also zero-extends a first beat.
    assign w_sum       = r_acc + OUT_W'(bus.in_data);
    assign w_emit_data = w_accept ? w_sum : r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_beat_cnt    <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_partial <= 1'b0;
            r_out_index   <= 8'd0;
            r_next_index  <= 8'd0;
        end else begin
            if (w_load) begin
                r_state    <= ST_IDLE;
                r_acc      <= '0;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_state    <= ST_ACCUM;
                r_acc      <= w_sum;
                r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
            end

            if (w_load) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= w_emit_data;
                r_out_partial <= !w_last;
                r_out_index   <= r_next_index;
                r_next_index  <= r_next_index + 8'd1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_partial = r_out_partial;
    assign bus.out_index   = r_out_index;

endmodule
`default_nettype wire

// File: doc/conv_row_accumulator.md
CONV_ROW_ACCUMULATOR -- requirements
Module: conv_row_accumulator

Interface
- REQ-001: The block SHALL have parameter IN_W, default 18, giving the width of one partial sum from the upstream 4-MAC convolution stage.
- REQ-002: The block SHALL have parameter ACC_LEN, default 4, giving the number of partial sums (kernel rows) per output; legal range is 2..16.
- REQ-003: The block SHALL have parameter OUT_W, default IN_W+4, giving the result width; IN_W+4 covers the worst case for any legal ACC_LEN.
- REQ-004: Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-005: Port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-006: Port enable, input, 1 bit: when low, input acceptance is frozen.
- REQ-007: Port in_valid, input, 1 bit: in_data holds a partial sum.
- REQ-008: Port in_data, input, IN_W bits: unsigned partial sum.
- REQ-009: Port in_ready, output, 1 bit: the block can accept in_data this cycle.
- REQ-010: Port flush, input, 1 bit: emit the current partial accumulation early.
- REQ-011: Port out_valid, output, 1 bit: out_data holds a result.
- REQ-012: Port out_ready, input, 1 bit: the consumer accepts the result.
- REQ-013: Port out_data, output, OUT_W bits: accumulated unsigned sum.
- REQ-014: Port out_partial, output, 1 bit: the result came from a flush with fewer than ACC_LEN beats.
- REQ-015: Port out_index, output, 8 bits: sequence number of the result; wraps from 255 to 0.

Function
- REQ-016: An input beat SHALL be accepted when in_valid && in_ready && enable are all high in the same cycle.
- REQ-017: in_ready SHALL equal enable && !(out_valid && !out_ready && (beat_cnt==ACC_LEN-1 || flush)); this is combinational from out_ready.
- REQ-018: The FSM SHALL have two states: IDLE (beat_cnt=0, acc=0) and ACCUM (0<beat_cnt<ACC_LEN).
- REQ-019: An accepted beat in IDLE SHALL load acc with in_data zero-extended, set beat_cnt to 1, and move the FSM to ACCUM.
- REQ-020: An accepted beat in ACCUM that is not the last beat SHALL set acc to acc+in_data and increment beat_cnt.
- REQ-021: The accepted beat with beat_cnt==ACC_LEN-1 SHALL complete the sum, with these effects on the next edge:
  - out_data <= acc+in_data
  - out_valid <= 1, out_partial <= 0
  - acc <= 0, beat_cnt <= 0, FSM -> IDLE
  - Latency: one cycle from the last beat to out_valid.
- REQ-022: flush high in ACCUM with no beat accepted SHALL emit acc with out_partial=1 and return the FSM to IDLE.
- REQ-023: flush high in ACCUM together with an accepted beat SHALL include that beat in the emitted sum.
- REQ-024: flush high in IDLE with no accepted beat SHALL be ignored.
- REQ-025: A flush emission SHALL require the output slot to be free or being drained this cycle; otherwise the flush SHALL be held off with no state change, and the requester keeps flush high.
- REQ-026: The output slot SHALL be a single register; out_data, out_partial and out_index SHALL stay stable while out_valid && !out_ready.
- REQ-027: out_valid SHALL clear on an out_valid && out_ready cycle unless a new result loads in the same cycle, in which case out_valid stays high and the new data replaces the old.
- REQ-028: out_index SHALL increment by 1 on every loaded result, whether full or partial; the first result after reset carries index 0.
- REQ-029: enable low SHALL freeze acc, beat_cnt and the FSM and force in_ready=0.
- REQ-030: The output handshake SHALL continue to operate while enable is low.
- REQ-031: Arithmetic SHALL be unsigned modulo 2^OUT_W; no saturation is needed for ACC_LEN<=16.

Reset
- REQ-032: While reset=0, the block SHALL asynchronously clear:
  - acc=0, beat_cnt=0, FSM=IDLE
  - out_valid=0, out_data=0, out_partial=0
  - out_index counter=0
  - in_ready evaluates to 0 because the block gates it with the synchronized reset release.
- REQ-033: A reset asserted mid-accumulation SHALL discard the partial sum; no result is emitted.
- REQ-034: The first beat accepted after reset release SHALL start a fresh sum.

Verification
- REQ-035: Back-to-back beats: ACC_LEN=4, out_ready=1, beats 1,2,3,4 on consecutive cycles -> out_data=10, out_partial=0, out_index=0, out_valid high for exactly one cycle, one cycle after beat 4.
- REQ-036: Width boundary: four beats of 262143 -> out_data=1048572 with no wrap; two back-to-back groups -> out_index 0 then 1.
- REQ-037: Backpressure: out_ready=0 holding result 10, then 3 more beats accepted, the 4th beat is offered -> in_ready=0 on the 4th beat until out_ready=1; no beat lost; second result correct.
- REQ-038: Flush:
  - beats 5,7, then flush -> out_data=12, out_partial=1, FSM back to IDLE.
  - flush in IDLE -> no output.
  - flush together with a beat of 3 after beat 5 -> out_data=8.
- REQ-039: Reset and stall:
  - reset asserted after 2 beats -> out_valid=0 immediately; the next 4 beats of 1 -> out_data=4, out_index=0.
  - enable=0 with in_valid=1 for 5 cycles -> in_ready=0 and no state change.
